zone_alarm_arbiter: RTL and testbench
=====================================

// Module: zone_alarm_arbiter
// PURPOSE
//  Shares one buzzer and one external voice player between the three distance-zone requesters
//  (1 m, 0.5 m, 20 cm threshold-crossing pulses from the distance calculator).
//  Latches requests, grants by fixed priority, runs a per-zone beep pattern, then a hold-off.
//  Sits between the distance calculator and the audio/buzzer outputs.
// PARAMETERS
//  CLK_FREQ      50_000_000  clock frequency in Hz
//  BEEP_MS       100         buzzer on-time per beep
//  GAP_MS        50          buzzer off-time between beeps
//  HOLDOFF_MS    500         quiet time after a completed pattern
//  REP_1M        1           beeps for the 1 m zone (1..7)
//  REP_0_5M      2           beeps for the 0.5 m zone (1..7)
//  REP_20CM      3           beeps for the 20 cm zone (1..7)
//  ACK_TO_CYC    1_000_000   player-ack timeout, in cycles (ALARM_ACK_TIMEOUT_EN only)
// PORTS
//  clk_50M       in   1  system clock
//  s_rst_n       in   1  asynchronous reset, active-low
//  meter_1_en    in   1  1-cycle pulse: entered 1 m zone
//  meter_0_5_en  in   1  1-cycle pulse: entered 0.5 m zone
//  cm_20_en      in   1  1-cycle pulse: entered 20 cm zone
//  mute          in   1  level: suppress all alarms
//  play_ack      in   1  1-cycle pulse from voice player: clip accepted
//  play_req      out  1  level: request clip; held until play_ack
//  play_idx      out  2  clip index = zone code; stable while play_req=1
//  buzzer        out  1  buzzer drive
//  zone_level    out  2  0=none, 1=1 m, 2=0.5 m, 3=20 cm; last granted zone
//  ack_timeout   out  1  1-cycle pulse on player timeout (ALARM_ACK_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, pending flags 0, FSM=IDLE. Reset mid-operation aborts immediately.
//  Timing: cycle counts = CLK_FREQ/1000*X_MS. Counters are 32-bit and saturate at terminal.
//  Pending: one flag per zone, set by its pulse.
//   - Set wins over a same-cycle clear.
//   - While mute=1, pulses are discarded and all pending flags are cleared.
//  Priority: 20 cm(3) > 0.5 m(2) > 1 m(1). On grant, the granted zone and all lower flags clear.
//  FSM:
//   IDLE: any pending & !mute -> REQ.
//     - Latch grant; zone_level<=grant; rep<=REP_x-1.
//     - play_req rises 2 cycles after the pulse cycle.
//   REQ: play_req=1, play_idx=grant.
//     - play_ack -> BEEP; play_req drops the next cycle.
//   BEEP: buzzer=1 for exactly BEEP cycles -> GAP.
//   GAP: buzzer=0 for GAP cycles. At end:
//     - higher-zone pending -> IDLE (preempt; remaining repeats dropped)
//     - else rep>0 -> BEEP, rep--
//     - else -> HOLD
//   HOLD: HOLDOFF cycles.
//     - Pulses of the granted or a lower zone are discarded.
//     - A higher-zone pulse ends HOLD next cycle -> IDLE.
//     - On expiry: zone_level<=0 -> IDLE.
//  Preemption never truncates a beep already in progress.
//  mute=1 in any state:
//   - next cycle FSM=IDLE, buzzer=0, play_req=0, zone_level=0.
//   - An ack arriving while muted is ignored.
//  Simultaneous pulses: all latched; only the highest is granted; lower ones are cleared at grant.
// CONFIGURATION
//  ALARM_ACK_TIMEOUT_EN defined:
//   - REQ counts cycles. After ACK_TO_CYC cycles without play_ack: ack_timeout pulses 1 cycle,
//     play_req drops, FSM -> BEEP (buzzer-only alarm).
//   - A late play_ack after the timeout is ignored.
//  Not defined: REQ waits indefinitely for play_ack; ack_timeout tied 0.
// TESTING
//  Parameters: CLK_FREQ=1000, BEEP_MS=4, GAP_MS=2, HOLDOFF_MS=10.
//  1. cm_20_en pulse; ack 1 cycle after play_req
//     -> play_idx=3; zone_level=3; 3 beeps of 4 cycles with 2-cycle gaps;
//        10-cycle HOLD; zone_level=0.
//  2. meter_1_en and cm_20_en in the same cycle
//     -> single grant with play_idx=3; no later 1 m request.
//  3. meter_0_5_en granted; cm_20_en during the first beep
//     -> the 4-cycle beep completes; the gap follows;
//        new play_req with play_idx=3; the second 0.5 m beep never occurs.
//  4. mute high during BEEP
//     -> buzzer 0 and zone_level 0 next cycle; meter_1_en during mute yields no play_req after unmute.
//  5. s_rst_n low during GAP
//     -> all outputs 0 asynchronously; idle after release until a new pulse.
//  6. ALARM_ACK_TIMEOUT_EN, ACK_TO_CYC=8, no ack
//     -> play_req high 8 cycles; ack_timeout 1 pulse; buzzer beeps per zone.

Source files
------------

// File: rtl/zone_alarm_arbiter.sv
// Arbitrates the 1 m / 0.5 m / 20 cm zone alarms onto one buzzer and one voice player.
// Define ALARM_ACK_TIMEOUT_EN to give up on a silent voice player after ACK_TO_CYC cycles.
module zone_alarm_arbiter #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BEEP_MS    = 100,
  parameter int unsigned GAP_MS     = 50,
  parameter int unsigned HOLDOFF_MS = 500,
  parameter int unsigned REP_1M     = 1,
  parameter int unsigned REP_0_5M   = 2,
  parameter int unsigned REP_20CM   = 3,
  parameter int unsigned ACK_TO_CYC = 1_000_000
) (
  input  logic       clk_50M,
  input  logic       s_rst_n,
  input  logic       meter_1_en,
  input  logic       meter_0_5_en,
  input  logic       cm_20_en,
  input  logic       mute,
  input  logic       play_ack,
  output logic       play_req,
  output logic [1:0] play_idx,
  output logic       buzzer,
  output logic [1:0] zone_level,
  output logic       ack_timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_BEEP = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [31:0] BEEP_CYC  = 32'(CLK_FREQ / 32'd1000 * BEEP_MS);
  localparam logic [31:0] GAP_CYC   = 32'(CLK_FREQ / 32'd1000 * GAP_MS);
  localparam logic [31:0] HOLD_CYC  = 32'(CLK_FREQ / 32'd1000 * HOLDOFF_MS);
  localparam logic [31:0] BEEP_TERM = (BEEP_CYC > 32'd0) ? BEEP_CYC - 32'd1 : 32'd0;
  localparam logic [31:0] GAP_TERM  = (GAP_CYC  > 32'd0) ? GAP_CYC  - 32'd1 : 32'd0;
  localparam logic [31:0] HOLD_TERM = (HOLD_CYC > 32'd0) ? HOLD_CYC - 32'd1 : 32'd0;
  localparam logic [31:0] ACK_TERM  = (ACK_TO_CYC > 32'd0) ? 32'(ACK_TO_CYC - 32'd1) : 32'd0;

  localparam logic [2:0] REP1_INIT = 3'(REP_1M   - 32'd1);
  localparam logic [2:0] REP2_INIT = 3'(REP_0_5M - 32'd1);
  localparam logic [2:0] REP3_INIT = 3'(REP_20CM - 32'd1);

  // Pending bit 2 = 20 cm (zone 3), bit 1 = 0.5 m (zone 2), bit 0 = 1 m (zone 1).
  function automatic logic [1:0] top_zone(input logic [2:0] p);
    if (p[2]) begin
      top_zone = 2'd3;
    end else if (p[1]) begin
      top_zone = 2'd2;
    end else if (p[0]) begin
      top_zone = 2'd1;
    end else begin
      top_zone = 2'd0;
    end
  endfunction

  function automatic logic [2:0] clear_mask(input logic [1:0] z);
    case (z)
      2'd3:    clear_mask = 3'b111;
      2'd2:    clear_mask = 3'b011;
      2'd1:    clear_mask = 3'b001;
      default: clear_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] higher_mask(input logic [1:0] z);
    case (z)
      2'd1:    higher_mask = 3'b110;
      2'd2:    higher_mask = 3'b100;
      default: higher_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] rep_init(input logic [1:0] z);
    case (z)
      2'd3:    rep_init = REP3_INIT;
      2'd2:    rep_init = REP2_INIT;
      default: rep_init = REP1_INIT;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  rep_q, rep_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  zone_q, zone_d;
  logic        tmo_q, tmo_d;
  logic        buzzer_q, play_req_q;

  logic [2:0]  set_s;
  logic [1:0]  top_s;
  logic [2:0]  hi_mask_s;
  logic [31:0] cnt_inc_s;
  logic        hold_hit_s;

  assign set_s      = {cm_20_en, meter_0_5_en, meter_1_en};
  assign top_s      = top_zone(pend_q);
  assign hi_mask_s  = higher_mask(grant_q);
  assign cnt_inc_s  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign hold_hit_s = |((pend_q | set_s) & hi_mask_s);

`ifndef ALARM_ACK_TIMEOUT_EN
  logic unused_ack_s;
  assign unused_ack_s = ^ACK_TERM;
`endif

  // Next-state logic: pending flags, grant, beep sequencing and mute override.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | set_s;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    grant_d = grant_q;
    zone_d  = zone_q;
    tmo_d   = 1'b0;
    if (mute) begin
      state_d = S_IDLE;
      pend_d  = 3'b000;
      cnt_d   = 32'd0;
      zone_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pend_q != 3'b000) begin
            state_d = S_REQ;
            grant_d = top_s;
            zone_d  = top_s;
            rep_d   = rep_init(top_s);
            pend_d  = (pend_q & ~clear_mask(top_s)) | set_s;
            cnt_d   = 32'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REQ: begin
          if (play_ack) begin
            state_d = S_BEEP;
            cnt_d   = 32'd0;
          end else begin
`ifdef ALARM_ACK_TIMEOUT_EN
            if (cnt_q >= ACK_TERM) begin
              state_d = S_BEEP;
              tmo_d   = 1'b1;
              cnt_d   = 32'd0;
            end else begin
              cnt_d = cnt_inc_s;
            end
`else
            cnt_d = cnt_q;
`endif
          end
        end
        S_BEEP: begin
          if (cnt_q >= BEEP_TERM) begin
            state_d = S_GAP;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_GAP: begin
          if (cnt_q >= GAP_TERM) begin
            cnt_d = 32'd0;
            if ((pend_q & hi_mask_s) != 3'b000) begin
              state_d = S_IDLE;
            end else if (rep_q != 3'd0) begin
              state_d = S_BEEP;
              rep_d   = rep_q - 3'd1;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_HOLD: begin
          // Only a more urgent zone may be latched or cut the hold-off short.
          pend_d = pend_q | (set_s & hi_mask_s);
          if (hold_hit_s) begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end else if (cnt_q >= HOLD_TERM) begin
            state_d = S_IDLE;
            zone_d  = 2'd0;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= 3'b000;
      cnt_q      <= 32'd0;
      rep_q      <= 3'd0;
      grant_q    <= 2'd0;
      zone_q     <= 2'd0;
      tmo_q      <= 1'b0;
      buzzer_q   <= 1'b0;
      play_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      grant_q    <= grant_d;
      zone_q     <= zone_d;
      tmo_q      <= tmo_d;
      buzzer_q   <= (state_d == S_BEEP);
      play_req_q <= (state_d == S_REQ);
    end
  end

  assign play_req    = play_req_q;
  assign play_idx    = grant_q;
  assign buzzer      = buzzer_q;
  assign zone_level  = zone_q;
  assign ack_timeout = tmo_q;

endmodule

// File: tb/tb_zone_alarm_arbiter.sv
// Scoreboard bench for zone_alarm_arbiter: per-cycle expected output vectors are queued
// with the stimulus and compared cycle by cycle on the falling clock edge.
module tb_zone_alarm_arbiter;

  logic       clk_50M = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       meter_1_en = 1'b0, meter_0_5_en = 1'b0, cm_20_en = 1'b0;
  logic       mute = 1'b0, play_ack = 1'b0;
  logic       play_req, buzzer, ack_timeout;
  logic [1:0] play_idx, zone_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_v, obs_v;

  // Vector layout: {play_req, play_idx (only meaningful while requesting), buzzer, zone_level, ack_timeout}
  localparam logic [6:0] ZERO = 7'b0000000;
  localparam logic [6:0] REQ1 = 7'b1010010;
  localparam logic [6:0] BUZ1 = 7'b0001010;
  localparam logic [6:0] Q1   = 7'b0000010;
  localparam logic [6:0] REQ2 = 7'b1100100;
  localparam logic [6:0] BUZ2 = 7'b0001100;
  localparam logic [6:0] Q2   = 7'b0000100;
  localparam logic [6:0] REQ3 = 7'b1110110;
  localparam logic [6:0] BUZ3 = 7'b0001110;
  localparam logic [6:0] Q3   = 7'b0000110;
  localparam logic [6:0] TMO3 = 7'b0001111;

  zone_alarm_arbiter #(
    .CLK_FREQ(1000), .BEEP_MS(4), .GAP_MS(2), .HOLDOFF_MS(10),
    .REP_1M(1), .REP_0_5M(2), .REP_20CM(3), .ACK_TO_CYC(8)
  ) dut (
    .clk_50M(clk_50M), .s_rst_n(s_rst_n),
    .meter_1_en(meter_1_en), .meter_0_5_en(meter_0_5_en), .cm_20_en(cm_20_en),
    .mute(mute), .play_ack(play_ack),
    .play_req(play_req), .play_idx(play_idx), .buzzer(buzzer),
    .zone_level(zone_level), .ack_timeout(ack_timeout)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic logic [6:0] obs_vec();
    return {play_req, (play_req ? play_idx : 2'b00), buzzer, zone_level, ack_timeout};
  endfunction

  task automatic push(input int n, input logic [6:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic clear_pulses();
    meter_1_en = 1'b0; meter_0_5_en = 1'b0; cm_20_en = 1'b0; play_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_pulses();
    mute = 1'b0;
    s_rst_n = 1'b0;
    repeat (2) @(negedge clk_50M);
    s_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_pulses();
    s_rst_n = 1'b0;
    cm_20_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_50M);
      n_checks++;
      if (obs_vec() !== ZERO) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b want %b", k, obs_vec(), ZERO);
      end
    end
    cm_20_en = 1'b0;
  endtask

  task automatic test_single_20cm();
    do_reset();
    push(2, ZERO); push(2, REQ3);
    push(4, BUZ3); push(2, Q3); push(4, BUZ3); push(2, Q3); push(4, BUZ3);
    push(12, Q3); push(2, ZERO);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL single_20cm cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0: cm_20_en = 1'b1;
        3: play_ack = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push(2, ZERO); push(2, REQ3);
    push(4, BUZ3); push(2, Q3); push(4, BUZ3); push(2, Q3); push(4, BUZ3);
    push(12, Q3); push(8, ZERO);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL simultaneous cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0: begin meter_1_en = 1'b1; cm_20_en = 1'b1; end
        3: play_ack = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic test_preempt();
    do_reset();
    push(2, ZERO); push(2, REQ2); push(4, BUZ2); push(3, Q2);
    push(2, REQ3); push(4, BUZ3); push(2, Q3); push(4, BUZ3); push(2, Q3); push(4, BUZ3);
    push(12, Q3); push(3, ZERO);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL preempt cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0:  meter_0_5_en = 1'b1;
        3:  play_ack = 1'b1;
        5:  cm_20_en = 1'b1;
        12: play_ack = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic test_mute();
    do_reset();
    push(2, ZERO); push(2, REQ3); push(2, BUZ3); push(15, ZERO);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL mute cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0:  cm_20_en = 1'b1;
        3:  play_ack = 1'b1;
        5:  mute = 1'b1;
        7:  meter_1_en = 1'b1;
        8:  play_ack = 1'b1;
        10: mute = 1'b0;
        default: ;
      endcase
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_in_gap();
    do_reset();
    push(2, ZERO); push(2, REQ3); push(4, BUZ3); push(1, Q3);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL rst_gap cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0: cm_20_en = 1'b1;
        3: play_ack = 1'b1;
        8: begin
          s_rst_n = 1'b0;
          #1;
          n_checks++;
          if (obs_vec() !== ZERO) begin
            n_fail++;
            $display("FAIL rst_gap async: got %b want %b", obs_vec(), ZERO);
          end
        end
        default: ;
      endcase
    end
    repeat (2) @(negedge clk_50M);
    s_rst_n = 1'b1;
    push(10, ZERO);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL rst_gap idle cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    push(2, ZERO); push(2, REQ1); push(4, BUZ1); push(12, Q1); push(8, ZERO);
    push(2, REQ1); push(4, BUZ1); push(6, Q1); push(2, REQ3);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL hold cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0:  meter_1_en = 1'b1;
        3:  play_ack = 1'b1;
        12: meter_1_en = 1'b1;
        26: meter_1_en = 1'b1;
        29: play_ack = 1'b1;
        38: cm_20_en = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic test_ack_timeout();
    do_reset();
`ifdef ALARM_ACK_TIMEOUT_EN
    push(2, ZERO); push(8, REQ3); push(1, TMO3); push(3, BUZ3);
    push(2, Q3); push(4, BUZ3); push(2, Q3); push(4, BUZ3); push(12, Q3); push(2, ZERO);
`else
    push(2, ZERO); push(28, REQ3); push(3, ZERO);
`endif
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk_50M);
      exp_v = exp_q.pop_front();
      obs_v = obs_vec();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL ack_timeout cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      clear_pulses();
      case (k)
        0:  cm_20_en = 1'b1;
`ifdef ALARM_ACK_TIMEOUT_EN
        11: play_ack = 1'b1;
`else
        29: mute = 1'b1;
`endif
        default: ;
      endcase
    end
    mute = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_20cm();
    test_simultaneous();
    test_preempt();
    test_mute();
    test_reset_in_gap();
    test_hold();
    test_ack_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
